// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two valid/ready requesters
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_z,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_z,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z
);

    // The downstream ALU has no default branch, so idle cycles must carry a defined code.
    localparam logic [OP_W-1:0] ALU_XXX = {OP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              z_q, z_d;
    logic              grant0, grant1;

`ifdef ALU_ARB_RR_EN
    logic              last_q, last_d;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !rst) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        owner_d = owner_q;
        res_d   = res_q;
        z_d     = z_q;
`ifdef ALU_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = EXEC;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    op_d    = grant1 ? req1_op : req0_op;
                    owner_d = grant1;
`ifdef ALU_ARB_RR_EN
                    last_d  = grant1;
`endif
                end
            end
            EXEC: begin
                res_d   = alu_out;
                z_d     = alu_z;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_XXX;
            owner_q <= 1'b0;
            res_q   <= '0;
            z_q     <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            res_q   <= res_d;
            z_q     <= z_d;
`ifdef ALU_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign rsp0_z     = z_q;
    assign rsp1_z     = z_q;

    assign alu_a  = (state_q == EXEC) ? a_q  : '0;
    assign alu_b  = (state_q == EXEC) ? b_q  : '0;
    assign alu_op = (state_q == EXEC) ? op_q : ALU_XXX;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a transaction model
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_XXX  = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_z, rsp1_z;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Stand-in for the external ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op);
    assign alu_z   = (alu_out == 32'd0);

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_z(rsp1_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_z(alu_z)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: at most one job in flight, aged in cycles since its accept.
    bit          m_on = 0;
    bit          m_busy = 0;
    int          m_age;
    bit          m_port;
    logic [31:0] m_a, m_b, m_res = '0;
    logic [3:0]  m_op;
    bit          m_z = 0;
    bit          m_last = 1;
    bit          e_r0, e_r1;

    always @(negedge clk) begin
        e_r0 = 0;
        e_r1 = 0;
        if (!m_busy && !rst) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                e_r0 = (m_last == 1);
                e_r1 = (m_last == 0);
            end else begin
                e_r0 = req0_valid;
                e_r1 = req1_valid;
            end
`else
            e_r0 = req0_valid;
            e_r1 = req1_valid && !req0_valid;
`endif
        end
        if (m_on) begin
            chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
            chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
            chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_busy && m_age >= 2 && m_port == 0});
            chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_busy && m_age >= 2 && m_port == 1});
            chk("m_rsp0_data", rsp0_data, m_res);
            chk("m_rsp1_data", rsp1_data, m_res);
            chk("m_rsp0_z", {31'd0, rsp0_z}, {31'd0, m_z});
            chk("m_rsp1_z", {31'd0, rsp1_z}, {31'd0, m_z});
            chk("m_alu_a", alu_a, (m_busy && m_age == 1) ? m_a : 32'd0);
            chk("m_alu_b", alu_b, (m_busy && m_age == 1) ? m_b : 32'd0);
            chk("m_alu_op", {28'd0, alu_op}, {28'd0, (m_busy && m_age == 1) ? m_op : OP_XXX});
        end
        if (rst) begin
            m_on   = 1;
            m_busy = 0;
            m_res  = '0;
            m_z    = 0;
            m_last = 1;
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_res = alu_f(m_a, m_b, m_op);
                m_z   = (m_res == 32'd0);
                m_age = 2;
            end else if (m_port ? rsp1_ready : rsp0_ready) begin
                m_busy = 0;
            end else begin
                m_age++;
            end
        end else if (e_r0 || e_r1) begin
            m_busy = 1;
            m_age  = 1;
            m_port = e_r1;
            m_last = e_r1;
            m_a    = e_r1 ? req1_a : req0_a;
            m_b    = e_r1 ? req1_b : req0_b;
            m_op   = e_r1 ? req1_op : req0_op;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          g_port[4];
    int          g_cyc[4];
    int          ng;
    bit          acc0, acc1;
    logic [31:0] held;

    initial begin
        // Reset state, with a request pending that must not be accepted.
        req0_valid = 1; req0_a = 32'd3; req0_b = 32'd4; req0_op = OP_ADDU;
        step(); step();
        @(negedge clk);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        req0_valid = 0;
        step();
        rst = 0;
        @(negedge clk);
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp_data", rsp0_data, 32'd0);
        chk("reset_alu_op", {28'd0, alu_op}, {28'd0, OP_XXX});

        // ADDU on port 0.
        step();
        req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADDU;
        @(negedge clk);
        chk("addu_req0_ready_T", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 0;
        @(negedge clk);
        chk("addu_alu_a_T1", alu_a, 32'd5);
        chk("addu_rsp0_valid_T1", {31'd0, rsp0_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("addu_rsp0_valid_T2", {31'd0, rsp0_valid}, 32'd1);
        chk("addu_rsp0_data", rsp0_data, 32'd12);
        chk("addu_rsp0_z", {31'd0, rsp0_z}, 32'd0);
        chk("addu_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        step();

        // SUBU on port 1, equal operands.
        req1_valid = 1; req1_a = 32'd9; req1_b = 32'd9; req1_op = OP_SUBU;
        @(negedge clk);
        chk("subu_req1_ready_T", {31'd0, req1_ready}, 32'd1);
        chk("subu_alu_op_T", {28'd0, alu_op}, {28'd0, OP_XXX});
        step(); req1_valid = 0;
        @(negedge clk);
        chk("subu_alu_op_T1", {28'd0, alu_op}, {28'd0, OP_SUBU});
        step();
        @(negedge clk);
        chk("subu_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("subu_rsp1_data", rsp1_data, 32'd0);
        chk("subu_rsp1_z", {31'd0, rsp1_z}, 32'd1);
        chk("subu_alu_op_T2", {28'd0, alu_op}, {28'd0, OP_XXX});
        step();

        // Both ports valid continuously; previous grant was port 1.
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = OP_ADDU;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = OP_SUBU;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            @(negedge clk);
            acc0 = req0_ready; acc1 = req1_ready;
            if (acc0 || acc1) begin
                g_port[ng] = acc1 ? 1 : 0;
                g_cyc[ng]  = c;
                ng++;
            end
            step();
            if (acc0) begin req0_a = $urandom; req0_b = $urandom; end
            if (acc1) begin req1_a = $urandom; req1_b = $urandom; end
        end
        chk("tie_grant_count", ng, 32'd4);
        for (int k = 0; k < 4 && k < ng; k++) begin
`ifdef ALU_ARB_RR_EN
            chk("tie_grant_port", g_port[k], k % 2);
`else
            chk("tie_grant_port", g_port[k], 32'd0);
`endif
            if (k > 0) chk("tie_grant_spacing", g_cyc[k] - g_cyc[k-1], 32'd3);
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) step();

        // Response backpressure with port 1 waiting.
        req0_valid = 1; req0_a = 32'd100; req0_b = 32'd23; req0_op = OP_ADDU;
        req1_valid = 1; req1_a = 32'd1;   req1_b = 32'd2;  req1_op = OP_ADDU;
        rsp0_ready = 0;
`ifdef ALU_ARB_RR_EN
        // Last grant in the tie run was port 1, so port 0 takes this tie too.
`endif
        @(negedge clk);
        chk("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 0;
        step();
        @(negedge clk);
        held = rsp0_data;
        chk("bp_rsp0_data", held, 32'd123);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid_hold", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_rsp0_data_hold", rsp0_data, held);
            chk("bp_req1_ready_blocked", {31'd0, req1_ready}, 32'd0);
            step();
        end
        rsp0_ready = 1;
        @(negedge clk);
        chk("bp_req1_ready_at_handshake", {31'd0, req1_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("bp_req1_ready_after", {31'd0, req1_ready}, 32'd1);
        step(); req1_valid = 0;
        for (int i = 0; i < 3; i++) step();

        // Reset while the job is in EXEC.
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADDU;
        @(negedge clk);
        chk("rx_req0_ready", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 0; rst = 1;
        step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rx_no_response", {31'd0, rsp0_valid}, 32'd0);
            step();
        end
        req0_valid = 1; req0_a = 32'd2; req0_b = 32'd3; req0_op = OP_ADDU;
        step(); req0_valid = 0;
        step();
        @(negedge clk);
        chk("rx_fresh_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("rx_fresh_data", rsp0_data, 32'd5);
        step();

        // Randomized traffic; requesters hold until accepted.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
            rst = ($urandom_range(0, 59) == 0);
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a  = $urandom;
                req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
                req0_op = 4'($urandom_range(0, 5));
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a  = $urandom;
                req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                req1_op = 4'($urandom_range(0, 5));
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 5; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
